// File: rtl/riscv_core_div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// Divides operand magnitudes and hands unsigned quotient/remainder plus the
// operand sign bits to the downstream result-fixup stage.
// Optional feature macro: RISCV_CORE_DIV_EARLY_OUT_EN. When it is defined, a
// zero divisor or |A| < |B| finishes right after accept with identical results.
//
// Handshake: a request is taken on a clock edge where i_div_valid=1,
// o_div_ready=1 and i_div_flush=0. A result is handed over on an edge where
// o_div_valid=1 and i_div_ready=1. Results stay stable while o_div_valid=1
// and i_div_ready=0. Neither valid signal depends combinationally on the
// other side's ready.
module riscv_core_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_div_flush,
  input  logic            i_div_valid,
  output logic            o_div_ready,
  input  logic [XLEN-1:0] i_div_srcA,
  input  logic [XLEN-1:0] i_div_srcB,
  input  logic [1:0]      i_div_control,
  input  logic            i_div_isword,
  output logic            o_div_valid,
  input  logic            i_div_ready,
  output logic [XLEN-1:0] o_div_quotient,
  output logic [XLEN-1:0] o_div_remainder,
  output logic            o_div_srcA_Dsign,
  output logic            o_div_srcB_Dsign,
  output logic            o_div_srcA_Wsign,
  output logic            o_div_srcB_Wsign,
  output logic [1:0]      o_div_control,
  output logic            o_div_isword,
  output logic [1:0]      o_div_state
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] HALF_MASK = {{(XLEN-HALF){1'b0}}, {HALF{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0] q_reg, r_reg, b_reg;
  logic [CW-1:0]   cnt;
  logic            sa_d, sb_d, sa_w, sb_w, isw_reg;
  logic [1:0]      ctrl_reg;

  logic            accept, signed_op;
  logic            a_dsign, b_dsign, a_wsign, b_wsign;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            b_zero, early_out;
  logic [XLEN:0]   rem_shift, rem_sub;
  logic            step_ge;

  assign accept = i_div_valid & (state == S_IDLE) & ~i_div_flush;

  // Operand preparation: sign extraction, word truncation and magnitude.
  always_comb begin
    signed_op = ~i_div_control[0];
    a_dsign   = signed_op & i_div_srcA[XLEN-1];
    b_dsign   = signed_op & i_div_srcB[XLEN-1];
    a_wsign   = signed_op & i_div_srcA[HALF-1];
    b_wsign   = signed_op & i_div_srcB[HALF-1];
    a_mag     = i_div_srcA;
    b_mag     = i_div_srcB;
    if (i_div_isword) begin
      a_mag = i_div_srcA & HALF_MASK;
      b_mag = i_div_srcB & HALF_MASK;
      if (a_wsign) a_mag = (~a_mag + 1'b1) & HALF_MASK;
      if (b_wsign) b_mag = (~b_mag + 1'b1) & HALF_MASK;
    end else begin
      if (a_dsign) a_mag = ~a_mag + 1'b1;
      if (b_dsign) b_mag = ~b_mag + 1'b1;
    end
    b_zero = (b_mag == '0);
  end

`ifdef RISCV_CORE_DIV_EARLY_OUT_EN
  assign early_out = b_zero | (a_mag < b_mag);
`else
  assign early_out = 1'b0;
`endif

  // One restoring step: shift the next dividend bit into R, subtract if it fits.
  always_comb begin
    rem_shift = {r_reg, q_reg[XLEN-1]};
    step_ge   = (rem_shift >= {1'b0, b_reg});
    rem_sub   = step_ge ? (rem_shift - {1'b0, b_reg}) : rem_shift;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush returns to IDLE from BUSY or DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = early_out ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (i_div_flush)           state_nxt = S_IDLE;
        else if (cnt == CW'(1))    state_nxt = S_DONE;
      end
      S_DONE: if (i_div_flush | i_div_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, iterate while BUSY.
  // Word dividends are pre-shifted so the MSB-first walk starts at bit HALF-1
  // and the quotient lands in the low half with the upper half zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_reg    <= '0;
      r_reg    <= '0;
      b_reg    <= '0;
      cnt      <= '0;
      sa_d     <= 1'b0;
      sb_d     <= 1'b0;
      sa_w     <= 1'b0;
      sb_w     <= 1'b0;
      ctrl_reg <= 2'b00;
      isw_reg  <= 1'b0;
    end else if (accept) begin
      sa_d     <= a_dsign;
      sa_w     <= a_wsign;
      // A zero divisor takes the dividend's signs so fixup leaves Q untouched.
      sb_d     <= b_zero ? a_dsign : b_dsign;
      sb_w     <= b_zero ? a_wsign : b_wsign;
      ctrl_reg <= i_div_control;
      isw_reg  <= i_div_isword;
      b_reg    <= b_mag;
      cnt      <= i_div_isword ? CW'(HALF) : CW'(XLEN);
      if (early_out) begin
        q_reg <= b_zero ? (i_div_isword ? HALF_MASK : '1) : '0;
        r_reg <= a_mag;
      end else begin
        q_reg <= i_div_isword ? (a_mag << HALF) : a_mag;
        r_reg <= '0;
      end
    end else if (state == S_BUSY) begin
      q_reg <= {q_reg[XLEN-2:0], step_ge};
      r_reg <= rem_sub[XLEN-1:0];
      cnt   <= cnt - CW'(1);
    end
  end

  // Output decode.
  always_comb begin
    o_div_ready      = (state == S_IDLE);
    o_div_valid      = (state == S_DONE);
    o_div_state      = state;
    o_div_quotient   = q_reg;
    o_div_remainder  = r_reg;
    o_div_srcA_Dsign = sa_d;
    o_div_srcB_Dsign = sb_d;
    o_div_srcA_Wsign = sa_w;
    o_div_srcB_Wsign = sb_w;
    o_div_control    = ctrl_reg;
    o_div_isword     = isw_reg;
  end

endmodule

// File: tb/tb_riscv_core_div_iter.sv
// Self-checking bench for riscv_core_div_iter (XLEN=32).
module tb_riscv_core_div_iter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            out_ready_dut;
  logic [XLEN-1:0] src_a, src_b;
  logic [1:0]      ctrl;
  logic            isw;
  logic            out_valid;
  logic            cons_ready;
  logic [XLEN-1:0] quo, rem;
  logic            sa_d, sb_d, sa_w, sb_w;
  logic [1:0]      ctrl_o;
  logic            isw_o;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Packed result: {Q, R, sA_D, sB_D, sA_W, sB_W, control, isword}
  logic [70:0] exp_q[$];
  logic [70:0] obs;
  assign obs = {quo, rem, sa_d, sb_d, sa_w, sb_w, ctrl_o, isw_o};

  riscv_core_div_iter #(.XLEN(XLEN)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_div_flush      (flush),
    .i_div_valid      (in_valid),
    .o_div_ready      (out_ready_dut),
    .i_div_srcA       (src_a),
    .i_div_srcB       (src_b),
    .i_div_control    (ctrl),
    .i_div_isword     (isw),
    .o_div_valid      (out_valid),
    .i_div_ready      (cons_ready),
    .o_div_quotient   (quo),
    .o_div_remainder  (rem),
    .o_div_srcA_Dsign (sa_d),
    .o_div_srcB_Dsign (sb_d),
    .o_div_srcA_Wsign (sa_w),
    .o_div_srcB_Wsign (sb_w),
    .o_div_control    (ctrl_o),
    .o_div_isword     (isw_o),
    .o_div_state      (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  // Reference model helpers.
  function automatic logic [31:0] mag(input logic [31:0] x, input logic neg, input logic w);
    logic [31:0] t;
    t = w ? {16'h0, x[15:0]} : x;
    if (neg) t = 32'h0 - t;
    if (w) t = t & 32'h0000FFFF;
    return t;
  endfunction

  function automatic logic [70:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] c, input logic w);
    logic sg, ad, bd, aw, bw;
    logic [31:0] am, bm, q, r;
    sg = ~c[0];
    ad = sg & a[31];
    bd = sg & b[31];
    aw = sg & a[15];
    bw = sg & b[15];
    am = mag(a, w ? aw : ad, w);
    bm = mag(b, w ? bw : bd, w);
    if (bm == 32'h0) begin
      q  = w ? 32'h0000FFFF : 32'hFFFFFFFF;
      r  = am;
      bd = ad;
      bw = aw;
    end else begin
      q = am / bm;
      r = am % bm;
    end
    return {q, r, ad, bd, aw, bw, c, w};
  endfunction

`ifdef RISCV_CORE_DIV_EARLY_OUT_EN
  function automatic logic is_early(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] c, input logic w);
    logic sg;
    logic [31:0] am, bm;
    sg = ~c[0];
    am = mag(a, w ? (sg & a[15]) : (sg & a[31]), w);
    bm = mag(b, w ? (sg & b[15]) : (sg & b[31]), w);
    return (bm == 32'h0) || (am < bm);
  endfunction
`endif

  // Driver: issue one op, check latency, results, hold stability and handshake.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                        input logic w, input logic [70:0] expv, input int hold);
    int lat, lat_exp;
    logic [70:0] e;
    lat_exp = (w ? 16 : 32) + 1;
`ifdef RISCV_CORE_DIV_EARLY_OUT_EN
    if (is_early(a, b, c, w)) lat_exp = 1;
`endif
    exp_q.push_back(expv);
    @(negedge clk);
    n_checks++;
    if (out_ready_dut !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: o_div_ready=%b required 1", out_ready_dut);
    end
    in_valid = 1'b1;
    src_a = a; src_b = b; ctrl = c; isw = w;
    @(negedge clk);
    in_valid = 1'b0;
    src_a = $urandom; src_b = $urandom;
    ctrl = 2'($urandom_range(0, 3)); isw = 1'($urandom_range(0, 1));
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL result_timeout: o_div_valid never rose, waited %0d cycles", lat);
      return;
    end
    if (lat != lat_exp) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles required %0d", lat, lat_exp);
    end
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL result: A=%h B=%h c=%b w=%b got Q=%h R=%h s=%b%b%b%b c=%b w=%b required Q=%h R=%h s=%b c=%b w=%b",
               a, b, c, w, quo, rem, sa_d, sb_d, sa_w, sb_w, ctrl_o, isw_o,
               e[70:39], e[38:7], e[6:3], e[2:1], e[0]);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== e || out_valid !== 1'b1 || out_ready_dut !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable cycle %0d: valid=%b ready=%b obs=%h required valid=1 ready=0 obs=%h",
                 i, out_valid, out_ready_dut, obs, e);
      end
    end
    cons_ready = 1'b1;
    @(negedge clk);
    cons_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_ready_dut !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake_idle: valid=%b ready=%b required valid=0 ready=1", out_valid, out_ready_dut);
    end
  endtask

  task automatic check_idle_clear(input string name);
    n_checks++;
    if (out_ready_dut !== 1'b1 || out_valid !== 1'b0 || obs !== 71'h0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL %s: ready=%b valid=%b state=%0d obs=%h required ready=1 valid=0 state=0 obs=0",
               name, out_ready_dut, out_valid, dbg_state, obs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_clear("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    run_op(32'hFFFFFFF9, 32'h2, 2'b00, 1'b0, {32'h3, 32'h1, 4'b1010, 2'b00, 1'b0}, 0);
    run_op(32'hFFFFFFF9, 32'h2, 2'b10, 1'b0, {32'h3, 32'h1, 4'b1010, 2'b10, 1'b0}, 0);
    run_op(32'hFFFFFFFF, 32'h10, 2'b01, 1'b0, {32'h0FFFFFFF, 32'hF, 4'b0000, 2'b01, 1'b0}, 0);
    run_op(32'hFFFFFFFF, 32'h10, 2'b11, 1'b0, {32'h0FFFFFFF, 32'hF, 4'b0000, 2'b11, 1'b0}, 0);
    run_op(32'hFFFFFFFB, 32'h0, 2'b00, 1'b0, {32'hFFFFFFFF, 32'h5, 4'b1111, 2'b00, 1'b0}, 0);
    run_op(32'h80000000, 32'hFFFFFFFF, 2'b00, 1'b0, {32'h80000000, 32'h0, 4'b1101, 2'b00, 1'b0}, 0);
  endtask

  task automatic test_word();
    run_op(32'h1234FFF9, 32'hABCD0002, 2'b00, 1'b1, {32'h3, 32'h1, 4'b0110, 2'b00, 1'b1}, 1);
    run_op(32'hFFFF1234, 32'h12340000, 2'b01, 1'b1, {32'h0000FFFF, 32'h00001234, 4'b0000, 2'b01, 1'b1}, 0);
    run_op(32'h00008000, 32'h0000FFFF, 2'b10, 1'b1, {32'h00008000, 32'h0, 4'b0011, 2'b10, 1'b1}, 0);
  endtask

  task automatic test_backpressure();
    run_op(32'd1000, 32'd33, 2'b01, 1'b0, {32'd30, 32'd10, 4'b0000, 2'b01, 1'b0}, 5);
  endtask

  task automatic test_flush_reset();
    int seen;
    @(negedge clk);
    in_valid = 1'b1; src_a = 32'd12345; src_b = 32'd7; ctrl = 2'b00; isw = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++;
    if (dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL flush_pre_busy: state=%0d required 1", dbg_state);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_ready_dut !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle: valid=%b ready=%b required valid=0 ready=1", out_valid, out_ready_dut);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_no_valid: o_div_valid high %0d cycles required 0", seen);
    end
    // Request coinciding with flush in IDLE must be ignored.
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    n_checks++;
    if (out_ready_dut !== 1'b1 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_blocks_accept: ready=%b state=%0d required ready=1 state=0", out_ready_dut, dbg_state);
    end
    // Reset in the middle of an op.
    in_valid = 1'b1; src_a = 32'hDEADBEEF; src_b = 32'd3; ctrl = 2'b01; isw = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    check_idle_clear("reset_mid_op");
    rst = 1'b0; flush = 1'b0;
    run_op(32'd100, 32'd7, 2'b01, 1'b0, {32'd14, 32'd2, 4'b0000, 2'b01, 1'b0}, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [1:0]  c;
    logic        w;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      case ($urandom_range(0, 3))
        0: b = ($urandom_range(0, 1) == 1) ? 32'h0 : 32'hFFFF0000;
        1: b = 32'($urandom_range(1, 15));
        2: b = $urandom;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      c = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      run_op(a, b, c, w, model(a, b, c, w), $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(8, 28);
      run_op(a, b, 2'(i), 1'b0, model(a, b, 2'(i), 1'b0), 0);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; cons_ready = 1'b0;
    src_a = '0; src_b = '0; ctrl = 2'b00; isw = 1'b0;
    test_reset();
    test_vectors();
    test_word();
    test_backpressure();
    test_flush_reset();
    test_random();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
